id_ex_stage: RTL and testbench

ID/EX pipeline stage of the 5-stage CPU: registers decoded instruction fields from ID, decodes the 3-bit ALU control, forwards results from EX/MEM and MEM/WB, and drives the ALU operands and control directly. It also detects load-use hazards, stalls ID/IF, and inserts a bubble into EX. Downstream consumers are the ALU and the EX/MEM register.

---
 rtl/id_ex_stage_pkg.sv | 65 ++++++
 rtl/id_ex_stage_alu_ctrl.sv | 27 ++
 rtl/id_ex_stage.sv | 112 +++++++++++
 tb/tb_id_ex_stage.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared encodings and the ID/EX register layout for the EX stage.
// The ALU consumes the same ALUCtrl encodings defined here.
package id_ex_stage_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_MUL = 3'b100
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_RTYPE = 2'b10,
        ALUOP_ADDI  = 2'b11
    } alu_op_e;

    // {funct7, funct3}
    localparam logic [9:0] FUNCT_ADD = {7'b0000000, 3'b000};
    localparam logic [9:0] FUNCT_SUB = {7'b0100000, 3'b000};
    localparam logic [9:0] FUNCT_MUL = {7'b0000001, 3'b000};
    localparam logic [9:0] FUNCT_AND = {7'b0000000, 3'b111};
    localparam logic [9:0] FUNCT_OR  = {7'b0000000, 3'b110};

    typedef struct packed {
        logic              valid;
        logic [REG_W-1:0]  rs1_addr;
        logic [REG_W-1:0]  rs2_addr;
        logic [REG_W-1:0]  rd_addr;
        logic [DATA_W-1:0] rs1_data;
        logic [DATA_W-1:0] rs2_data;
        logic [DATA_W-1:0] imm;
        alu_ctrl_e         alu_ctrl;
        logic              alu_src;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              mem_to_reg;
    } ex_fields_t;

    // EX/MEM has priority over MEM/WB; x0 is never forwarded.
    function automatic logic [DATA_W-1:0] forward_operand(
        input logic [REG_W-1:0]  rs_addr,
        input logic [DATA_W-1:0] rs_data,
        input logic              exmem_we,
        input logic [REG_W-1:0]  exmem_rd,
        input logic [DATA_W-1:0] exmem_res,
        input logic              memwb_we,
        input logic [REG_W-1:0]  memwb_rd,
        input logic [DATA_W-1:0] memwb_res
    );
        if (exmem_we && (exmem_rd != '0) && (exmem_rd == rs_addr)) begin
            return exmem_res;
        end else if (memwb_we && (memwb_rd != '0) && (memwb_rd == rs_addr)) begin
            return memwb_res;
        end
        return rs_data;
    endfunction

endpackage

// File: rtl/id_ex_stage_alu_ctrl.sv
// Combinational ALU control decoder: (ALUOp, {funct7,funct3}) -> ALUCtrl.
module alu_ctrl
    import id_ex_stage_pkg::*;
(
    input  logic [1:0] alu_op_i,
    input  logic [9:0] funct_i,
    output alu_ctrl_e  alu_ctrl_o
);

    always_comb begin
        alu_ctrl_o = ALU_ADD;
        case (alu_op_e'(alu_op_i))
            ALUOP_SUB: alu_ctrl_o = ALU_SUB;
            ALUOP_RTYPE: begin
                case (funct_i)
                    FUNCT_SUB: alu_ctrl_o = ALU_SUB;
                    FUNCT_MUL: alu_ctrl_o = ALU_MUL;
                    FUNCT_AND: alu_ctrl_o = ALU_AND;
                    FUNCT_OR:  alu_ctrl_o = ALU_OR;
                    default:   alu_ctrl_o = ALU_ADD;
                endcase
            end
            default: alu_ctrl_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU control decode, operand forwarding
// and load-use hazard detection (stall upstream, bubble into EX).
module id_ex_stage
    import id_ex_stage_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        id_valid_i,
    input  logic [4:0]  id_rs1_addr_i,
    input  logic [4:0]  id_rs2_addr_i,
    input  logic [4:0]  id_rd_addr_i,
    input  logic [31:0] id_rs1_data_i,
    input  logic [31:0] id_rs2_data_i,
    input  logic [31:0] id_imm_i,
    input  logic [9:0]  id_funct_i,
    input  logic [1:0]  id_alu_op_i,
    input  logic        id_alu_src_i,
    input  logic        id_reg_write_i,
    input  logic        id_mem_read_i,
    input  logic        id_mem_write_i,
    input  logic        id_mem_to_reg_i,
    input  logic        flush_i,
    input  logic        exmem_reg_write_i,
    input  logic [4:0]  exmem_rd_addr_i,
    input  logic [31:0] exmem_result_i,
    input  logic        memwb_reg_write_i,
    input  logic [4:0]  memwb_rd_addr_i,
    input  logic [31:0] memwb_result_i,
    output logic        stall_o,
    output logic        ex_valid_o,
    output logic [31:0] data1_o,
    output logic [31:0] data2_o,
    output logic [2:0]  ALUCtrl_o,
    output logic [31:0] ex_store_data_o,
    output logic [4:0]  ex_rd_addr_o,
    output logic        ex_reg_write_o,
    output logic        ex_mem_read_o,
    output logic        ex_mem_write_o,
    output logic        ex_mem_to_reg_o
);

    ex_fields_t  ex_q;
    ex_fields_t  ex_d;
    alu_ctrl_e   id_alu_ctrl;
    logic        load_use;
    logic [31:0] fwd_rs1;
    logic [31:0] fwd_rs2;

    alu_ctrl u_alu_ctrl (
        .alu_op_i   (id_alu_op_i),
        .funct_i    (id_funct_i),
        .alu_ctrl_o (id_alu_ctrl)
    );

    // rs2 is compared even for I-type; a spurious one-cycle stall is harmless.
    always_comb begin
        load_use = id_valid_i && ex_q.valid && ex_q.mem_read && (ex_q.rd_addr != '0) &&
                   ((ex_q.rd_addr == id_rs1_addr_i) || (ex_q.rd_addr == id_rs2_addr_i));
        stall_o  = load_use && !flush_i;
    end

    // Flush and stall both turn into an all-zero bubble.
    always_comb begin
        ex_d = '0;
        if (!flush_i && !stall_o) begin
            ex_d.valid      = id_valid_i;
            ex_d.rs1_addr   = id_rs1_addr_i;
            ex_d.rs2_addr   = id_rs2_addr_i;
            ex_d.rd_addr    = id_rd_addr_i;
            ex_d.rs1_data   = id_rs1_data_i;
            ex_d.rs2_data   = id_rs2_data_i;
            ex_d.imm        = id_imm_i;
            ex_d.alu_ctrl   = id_alu_ctrl;
            ex_d.alu_src    = id_alu_src_i;
            ex_d.reg_write  = id_reg_write_i;
            ex_d.mem_read   = id_mem_read_i;
            ex_d.mem_write  = id_mem_write_i;
            ex_d.mem_to_reg = id_mem_to_reg_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    always_comb begin
        fwd_rs1 = forward_operand(ex_q.rs1_addr, ex_q.rs1_data,
                                  exmem_reg_write_i, exmem_rd_addr_i, exmem_result_i,
                                  memwb_reg_write_i, memwb_rd_addr_i, memwb_result_i);
        fwd_rs2 = forward_operand(ex_q.rs2_addr, ex_q.rs2_data,
                                  exmem_reg_write_i, exmem_rd_addr_i, exmem_result_i,
                                  memwb_reg_write_i, memwb_rd_addr_i, memwb_result_i);
    end

    always_comb begin
        ex_valid_o      = ex_q.valid;
        data1_o         = fwd_rs1;
        data2_o         = ex_q.alu_src ? ex_q.imm : fwd_rs2;
        ALUCtrl_o       = ex_q.alu_ctrl;
        ex_store_data_o = fwd_rs2;
        ex_rd_addr_o    = ex_q.rd_addr;
        ex_reg_write_o  = ex_q.reg_write;
        ex_mem_read_o   = ex_q.mem_read;
        ex_mem_write_o  = ex_q.mem_write;
        ex_mem_to_reg_o = ex_q.mem_to_reg;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a behavioural model predicts every cycle's
// outputs into a queue, and a monitor pops and compares them against the DUT.
module tb_id_ex_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        id_valid_i;
    logic [4:0]  id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i;
    logic [31:0] id_rs1_data_i, id_rs2_data_i, id_imm_i;
    logic [9:0]  id_funct_i;
    logic [1:0]  id_alu_op_i;
    logic        id_alu_src_i, id_reg_write_i, id_mem_read_i, id_mem_write_i, id_mem_to_reg_i;
    logic        flush_i;
    logic        exmem_reg_write_i;
    logic [4:0]  exmem_rd_addr_i;
    logic [31:0] exmem_result_i;
    logic        memwb_reg_write_i;
    logic [4:0]  memwb_rd_addr_i;
    logic [31:0] memwb_result_i;
    logic        stall_o, ex_valid_o;
    logic [31:0] data1_o, data2_o, ex_store_data_o;
    logic [2:0]  ALUCtrl_o;
    logic [4:0]  ex_rd_addr_o;
    logic        ex_reg_write_o, ex_mem_read_o, ex_mem_write_o, ex_mem_to_reg_o;

    id_ex_stage dut (
        .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id_valid_i),
        .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i), .id_rd_addr_i(id_rd_addr_i),
        .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i), .id_imm_i(id_imm_i),
        .id_funct_i(id_funct_i), .id_alu_op_i(id_alu_op_i), .id_alu_src_i(id_alu_src_i),
        .id_reg_write_i(id_reg_write_i), .id_mem_read_i(id_mem_read_i),
        .id_mem_write_i(id_mem_write_i), .id_mem_to_reg_i(id_mem_to_reg_i), .flush_i(flush_i),
        .exmem_reg_write_i(exmem_reg_write_i), .exmem_rd_addr_i(exmem_rd_addr_i),
        .exmem_result_i(exmem_result_i), .memwb_reg_write_i(memwb_reg_write_i),
        .memwb_rd_addr_i(memwb_rd_addr_i), .memwb_result_i(memwb_result_i),
        .stall_o(stall_o), .ex_valid_o(ex_valid_o), .data1_o(data1_o), .data2_o(data2_o),
        .ALUCtrl_o(ALUCtrl_o), .ex_store_data_o(ex_store_data_o), .ex_rd_addr_o(ex_rd_addr_o),
        .ex_reg_write_o(ex_reg_write_o), .ex_mem_read_o(ex_mem_read_o),
        .ex_mem_write_o(ex_mem_write_o), .ex_mem_to_reg_o(ex_mem_to_reg_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic        rst, vld;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] d1, d2, imm;
        logic [9:0]  funct;
        logic [1:0]  op;
        logic        src, rw, mr, mw, m2r, flush;
        logic        xw;
        logic [4:0]  xrd;
        logic [31:0] xres;
        logic        ww;
        logic [4:0]  wrd;
        logic [31:0] wres;
    } stim_t;

    // What the model believes sits in EX: an instruction (or nothing).
    typedef struct packed {
        logic        vld;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] d1, d2, imm;
        logic [2:0]  ctrl;
        logic        src, rw, mr, mw, m2r;
    } instr_t;

    typedef struct packed {
        logic        stall, vld;
        logic [31:0] d1, d2, store;
        logic [2:0]  ctrl;
        logic [4:0]  rd;
        logic        rw, mr, mw, m2r;
    } exp_t;

    exp_t   exp_q[$];
    instr_t in_ex;
    bit     known;
    int     compared   = 0;
    int     mismatched = 0;

    function automatic logic [2:0] ref_ctrl(input logic [1:0] op, input logic [9:0] funct);
        if (op == 2'd1) return 3'd1;
        if (op != 2'd2) return 3'd0;
        if (funct == 10'b0100000_000) return 3'd1;
        if (funct == 10'b0000001_000) return 3'd4;
        if (funct == 10'b0000000_111) return 3'd2;
        if (funct == 10'b0000000_110) return 3'd3;
        return 3'd0;
    endfunction

    function automatic logic [31:0] ref_fwd(input logic [4:0] a, input logic [31:0] d, input stim_t s);
        if (s.xw && s.xrd != 0 && s.xrd == a) return s.xres;
        if (s.ww && s.wrd != 0 && s.wrd == a) return s.wres;
        return d;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic do_cycle(input stim_t s);
        exp_t   e;
        logic   hazard;
        instr_t nxt;
        @(negedge clk_i);
        rst_i = s.rst; id_valid_i = s.vld;
        id_rs1_addr_i = s.rs1; id_rs2_addr_i = s.rs2; id_rd_addr_i = s.rd;
        id_rs1_data_i = s.d1; id_rs2_data_i = s.d2; id_imm_i = s.imm;
        id_funct_i = s.funct; id_alu_op_i = s.op; id_alu_src_i = s.src;
        id_reg_write_i = s.rw; id_mem_read_i = s.mr; id_mem_write_i = s.mw;
        id_mem_to_reg_i = s.m2r; flush_i = s.flush;
        exmem_reg_write_i = s.xw; exmem_rd_addr_i = s.xrd; exmem_result_i = s.xres;
        memwb_reg_write_i = s.ww; memwb_rd_addr_i = s.wrd; memwb_result_i = s.wres;

        hazard = s.vld && in_ex.vld && in_ex.mr && in_ex.rd != 0 &&
                 (in_ex.rd == s.rs1 || in_ex.rd == s.rs2) && !s.flush;
        if (known) begin
            e.stall = hazard;
            e.vld   = in_ex.vld;
            e.d1    = ref_fwd(in_ex.rs1, in_ex.d1, s);
            e.store = ref_fwd(in_ex.rs2, in_ex.d2, s);
            e.d2    = in_ex.src ? in_ex.imm : e.store;
            e.ctrl  = in_ex.ctrl;
            e.rd    = in_ex.rd;
            e.rw    = in_ex.rw; e.mr = in_ex.mr; e.mw = in_ex.mw; e.m2r = in_ex.m2r;
            exp_q.push_back(e);
        end

        nxt = '0;
        if (!s.rst && !s.flush && !hazard) begin
            nxt.vld = s.vld; nxt.rs1 = s.rs1; nxt.rs2 = s.rs2; nxt.rd = s.rd;
            nxt.d1 = s.d1; nxt.d2 = s.d2; nxt.imm = s.imm; nxt.ctrl = ref_ctrl(s.op, s.funct);
            nxt.src = s.src; nxt.rw = s.rw; nxt.mr = s.mr; nxt.mw = s.mw; nxt.m2r = s.m2r;
        end
        in_ex = nxt;
        if (s.rst) known = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk_i);
            #1;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("stall_o",         {31'd0, stall_o},         {31'd0, e.stall});
                chk("ex_valid_o",      {31'd0, ex_valid_o},      {31'd0, e.vld});
                chk("data1_o",         data1_o,                  e.d1);
                chk("data2_o",         data2_o,                  e.d2);
                chk("ex_store_data_o", ex_store_data_o,          e.store);
                chk("ALUCtrl_o",       {29'd0, ALUCtrl_o},       {29'd0, e.ctrl});
                chk("ex_rd_addr_o",    {27'd0, ex_rd_addr_o},    {27'd0, e.rd});
                chk("ex_ctrl_bits",
                    {28'd0, ex_reg_write_o, ex_mem_read_o, ex_mem_write_o, ex_mem_to_reg_o},
                    {28'd0, e.rw, e.mr, e.mw, e.m2r});
            end
        end
    end

    stim_t s;
    logic [9:0] functs[6];

    initial begin
        rst_i = 1'b1; id_valid_i = 0; id_rs1_addr_i = 0; id_rs2_addr_i = 0; id_rd_addr_i = 0;
        id_rs1_data_i = 0; id_rs2_data_i = 0; id_imm_i = 0; id_funct_i = 0; id_alu_op_i = 0;
        id_alu_src_i = 0; id_reg_write_i = 0; id_mem_read_i = 0; id_mem_write_i = 0;
        id_mem_to_reg_i = 0; flush_i = 0; exmem_reg_write_i = 0; exmem_rd_addr_i = 0;
        exmem_result_i = 0; memwb_reg_write_i = 0; memwb_rd_addr_i = 0; memwb_result_i = 0;
        in_ex = '0; known = 1'b0;
        functs[0] = 10'b0000000_000; functs[1] = 10'b0100000_000; functs[2] = 10'b0000001_000;
        functs[3] = 10'b0000000_111; functs[4] = 10'b0000000_110; functs[5] = 10'b1111111_101;

        s = '0; s.rst = 1; do_cycle(s); do_cycle(s);
        s = '0; do_cycle(s);                                  // post-reset outputs all zero

        // MUL decode and plain operands
        s = '0; s.vld = 1; s.op = 2'b10; s.funct = 10'b0000001_000;
        s.rs1 = 1; s.rs2 = 2; s.rd = 4; s.d1 = 6; s.d2 = 7; s.rw = 1; do_cycle(s);
        s = '0; do_cycle(s);

        // EX/MEM beats MEM/WB, then rd=0 on EX/MEM lets MEM/WB through
        s = '0; s.vld = 1; s.rs1 = 5; s.d1 = 32'h99; do_cycle(s);
        s = '0; s.xw = 1; s.xrd = 5; s.xres = 32'h1234; s.ww = 1; s.wrd = 5; s.wres = 32'hBEEF;
        s.vld = 1; s.rs1 = 5; s.d1 = 32'h99; do_cycle(s);
        s.vld = 0; s.xrd = 0; do_cycle(s);

        // Load-use: lw x3 then add using x3 as rs2, ID held through the stall
        s = '0; s.vld = 1; s.mr = 1; s.rw = 1; s.m2r = 1; s.rd = 3; s.rs1 = 1; s.imm = 8;
        s.src = 1; do_cycle(s);
        s = '0; s.vld = 1; s.rs1 = 1; s.rs2 = 3; s.rd = 6; s.rw = 1; s.op = 2'b10; do_cycle(s);
        do_cycle(s);
        s = '0; do_cycle(s);

        // Flush concurrent with load-use hazard
        s = '0; s.vld = 1; s.mr = 1; s.rw = 1; s.rd = 3; do_cycle(s);
        s = '0; s.vld = 1; s.rs1 = 3; s.rw = 1; s.mw = 1; s.flush = 1; do_cycle(s);
        s = '0; do_cycle(s);

        // Immediate operand with forwarded store data
        s = '0; s.vld = 1; s.src = 1; s.imm = 32'hFFFF_FFFC; s.rs2 = 9; s.d2 = 32'h11;
        s.mw = 1; s.op = 2'b11; do_cycle(s);
        s = '0; s.xw = 1; s.xrd = 9; s.xres = 32'h55; do_cycle(s);

        // Reset mid-stream
        s = '0; s.vld = 1; s.rw = 1; s.rd = 7; s.op = 2'b01; s.d1 = 32'hA5; s.rs1 = 2; do_cycle(s);
        s.rst = 1; do_cycle(s);
        s = '0; do_cycle(s);

        // Random traffic on a small register window to provoke hazards and forwarding
        for (int i = 0; i < 400; i++) begin
            s = '0;
            s.rst   = ($urandom_range(0, 39) == 0);
            s.vld   = ($urandom_range(0, 4) != 0);
            s.rs1   = 5'($urandom_range(0, 3));
            s.rs2   = 5'($urandom_range(0, 3));
            s.rd    = 5'($urandom_range(0, 3));
            s.d1    = $urandom; s.d2 = $urandom; s.imm = $urandom;
            s.funct = functs[$urandom_range(0, 5)];
            s.op    = 2'($urandom_range(0, 3));
            s.src   = 1'($urandom_range(0, 1));
            s.rw    = 1'($urandom_range(0, 1));
            s.mr    = ($urandom_range(0, 2) == 0);
            s.mw    = 1'($urandom_range(0, 1));
            s.m2r   = 1'($urandom_range(0, 1));
            s.flush = ($urandom_range(0, 7) == 0);
            s.xw    = 1'($urandom_range(0, 1));
            s.xrd   = 5'($urandom_range(0, 3));
            s.xres  = $urandom;
            s.ww    = 1'($urandom_range(0, 1));
            s.wrd   = 5'($urandom_range(0, 3));
            s.wres  = $urandom;
            do_cycle(s);
        end

        s = '0; do_cycle(s);
        @(negedge clk_i);
        #2;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
